// File: rtl/jk_seq_pkg.sv
// Shared types and constants for the JK-based sequential-logic library.
// Holds the JK action encoding, a constant clog2 and the default counter geometry.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_action_t;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 10;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop bit with synchronous active-low reset.
// {j,k} = 00 hold, 01 clear, 10 set, 11 toggle.
module jk_cell
  import jk_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_b
);

  jk_action_t action;
  logic       state_d;
  logic       state_q;

  always_comb begin
    action  = jk_action_t'({j, k});
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (action)
      HOLD:   state_d = state_q;
      RESET:  state_d = 1'b0;
      SET:    state_d = 1'b1;
      TOGGLE: state_d = ~state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (!reset) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q   = state_q;
  assign q_b = ~state_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous modulo-MODULUS up/down counter built from WIDTH jk_cell bits.
// Parent computes the next count and derives each cell's j/k so the cells land on it.
module jk_sync_counter
  import jk_seq_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_b,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $fatal(1, "jk_sync_counter: WIDTH out of range 2..16");
  end
  if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
    $fatal(1, "jk_sync_counter: MODULUS out of range 2..2**WIDTH");
  end

  // One extra bit keeps MODULUS = 2**WIDTH representable in the compare.
  localparam logic [WIDTH:0] MOD_X = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_X = (WIDTH + 1)'(MODULUS - 1);

  logic [WIDTH:0]   q_x;
  logic [WIDTH:0]   d_x;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] next_d;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             wrap_d;
  logic             wrap_q;

  always_comb begin
    q_x     = {1'b0, q};
    d_x     = {1'b0, d};
    at_max  = (q_x == MAX_X);
    at_zero = (q_x == '0);
    next_d  = q;
    wrap_d  = 1'b0;
    if (!reset) begin
      next_d = '0;
    end else if (load) begin
      next_d = (d_x < MOD_X) ? d : MAX_X[WIDTH-1:0];
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          next_d = '0;
          wrap_d = 1'b1;
        end else begin
          next_d = WIDTH'(q_x + 1'b1);
        end
      end else begin
        if (at_zero) begin
          next_d = MAX_X[WIDTH-1:0];
          wrap_d = 1'b1;
        end else begin
          next_d = WIDTH'(q_x - 1'b1);
        end
      end
    end
    // Drive only the bits that must change: set 0->1, clear 1->0, never both.
    j_vec = next_d & ~q;
    k_vec = ~next_d & q;
    tc    = reset & ~load & en & ((up & at_max) | (~up & at_zero));
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j_vec[i]),
      .k     (k_vec[i]),
      .q     (q[i]),
      .q_b   (q_b[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench for jk_sync_counter: default (4-bit, mod 10) and full-range (3-bit, mod 8) instances.
// Driver pushes the hand-computed expectation for each cycle; a negedge monitor pops and compares.
module tb_jk_sync_counter;

  logic       clk;
  logic       rst0, en0, up0, ld0;
  logic [3:0] d0, q0, qb0;
  logic       tc0, wrap0;
  logic       rst1, en1, up1, ld1;
  logic [2:0] d1, q1, qb1;
  logic       tc1, wrap1;

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut_dec (
    .clk(clk), .reset(rst0), .en(en0), .up(up0), .load(ld0), .d(d0),
    .q(q0), .q_b(qb0), .tc(tc0), .wrap(wrap0)
  );

  jk_sync_counter #(.WIDTH(3), .MODULUS(8)) dut_full (
    .clk(clk), .reset(rst1), .en(en1), .up(up1), .load(ld1), .d(d1),
    .q(q1), .q_b(qb1), .tc(tc1), .wrap(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus what must be observed during that cycle
  // (q/wrap reflect the previous edge, tc reflects this cycle's inputs).
  typedef struct {
    bit         dut;
    bit         rst;
    bit         en;
    bit         up;
    bit         ld;
    logic [3:0] d;
    logic [3:0] q;
    bit         tc;
    bit         wrap;
  } vec_t;

  typedef struct {
    int         idx;
    bit         dut;
    logic [3:0] q;
    bit         tc;
    bit         wrap;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   jk_viol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input bit dut, input bit rst, input bit en, input bit up, input bit ld,
                   input logic [3:0] d, input logic [3:0] q, input bit tc, input bit wrap);
    vec_t x;
    x.dut = dut; x.rst = rst; x.en = en; x.up = up; x.ld = ld;
    x.d = d; x.q = q; x.tc = tc; x.wrap = wrap;
    vecs.push_back(x);
  endtask

  // Monitor: compares whatever expectation the driver issued for this cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      string tag;
      e = sb.pop_front();
      tag = $sformatf("v%0d_%s", e.idx, e.dut ? "full" : "dec");
      if (!e.dut) begin
        check({tag, "_q"},    {28'd0, q0},  {28'd0, e.q});
        check({tag, "_qb"},   {28'd0, qb0}, {28'd0, ~e.q});
        check({tag, "_tc"},   {31'd0, tc0},   {31'd0, e.tc});
        check({tag, "_wrap"}, {31'd0, wrap0}, {31'd0, e.wrap});
      end else begin
        check({tag, "_q"},    {29'd0, q1},  {29'd0, e.q[2:0]});
        check({tag, "_qb"},   {29'd0, qb1}, {29'd0, ~e.q[2:0]});
        check({tag, "_tc"},   {31'd0, tc1},   {31'd0, e.tc});
        check({tag, "_wrap"}, {31'd0, wrap1}, {31'd0, e.wrap});
      end
    end
  end

  // Illegal j=k=1 drive watcher on every bit of both instances.
  always @(negedge clk) begin
    if ((dut_dec.j_vec & dut_dec.k_vec) != 4'd0) jk_viol++;
    if ((dut_full.j_vec & dut_full.k_vec) != 3'd0) jk_viol++;
  end

  initial begin
    // Reset hold (3 cycles, en=up=1)
    for (int i = 0; i < 3; i++) v(0, 0, 1, 1, 0, 4'd0, 4'd0, 0, 0);
    // Up-count wrap: q 0..9 then 0,1
    for (int i = 0; i < 10; i++) v(0, 1, 1, 1, 0, 4'd0, 4'(i), (i == 9), 0);
    v(0, 1, 1, 1, 0, 4'd0, 4'd0, 0, 1);
    v(0, 1, 1, 1, 0, 4'd0, 4'd1, 0, 0);
    // Down-count wrap: load 2, then 2,1,0,9,8
    v(0, 1, 0, 0, 1, 4'd2, 4'd2, 0, 0);
    v(0, 1, 1, 0, 0, 4'd0, 4'd2, 0, 0);
    v(0, 1, 1, 0, 0, 4'd0, 4'd1, 0, 0);
    v(0, 1, 1, 0, 0, 4'd0, 4'd0, 1, 0);
    v(0, 1, 1, 0, 0, 4'd0, 4'd9, 0, 1);
    v(0, 1, 1, 0, 0, 4'd0, 4'd8, 0, 0);
    // Load beats en and saturates; then in-range load
    v(0, 1, 1, 1, 1, 4'd13, 4'd7, 0, 0);
    v(0, 1, 0, 0, 1, 4'd5,  4'd9, 0, 0);
    v(0, 1, 1, 1, 0, 4'd0,  4'd5, 0, 0);
    v(0, 1, 1, 1, 0, 4'd0,  4'd6, 0, 0);
    // Reset mid-count with load and en at q=7, then resume
    v(0, 0, 1, 1, 1, 4'd3, 4'd7, 0, 0);
    v(0, 1, 1, 1, 0, 4'd0, 4'd0, 0, 0);
    v(0, 1, 0, 1, 0, 4'd0, 4'd1, 0, 0);
    v(0, 1, 0, 0, 0, 4'd0, 4'd1, 0, 0);
    // Reset then immediate down tc at q=0
    v(0, 0, 1, 0, 0, 4'd0, 4'd1, 0, 0);
    v(0, 1, 1, 0, 0, 4'd0, 4'd0, 1, 0);
    v(0, 1, 0, 0, 0, 4'd0, 4'd9, 0, 1);
    // Full-range instance: 0..7 then 0, single wrap
    v(1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0);
    for (int i = 0; i < 8; i++) v(1, 1, 1, 1, 0, 4'd0, 4'(i), (i == 7), 0);
    v(1, 1, 1, 1, 0, 4'd0, 4'd0, 0, 1);
    v(1, 1, 0, 1, 0, 4'd0, 4'd1, 0, 0);

    rst0 = 1'b0; en0 = 1'b0; up0 = 1'b0; ld0 = 1'b0; d0 = 4'd0;
    rst1 = 1'b0; en1 = 1'b0; up1 = 1'b0; ld1 = 1'b0; d1 = 3'd0;
    @(posedge clk);

    for (int n = 0; n < vecs.size(); n++) begin
      exp_t e;
      #2;
      if (!vecs[n].dut) begin
        rst0 = vecs[n].rst; en0 = vecs[n].en; up0 = vecs[n].up;
        ld0 = vecs[n].ld;   d0 = vecs[n].d;
      end else begin
        rst0 = 1'b1; en0 = 1'b0; ld0 = 1'b0;
        rst1 = vecs[n].rst; en1 = vecs[n].en; up1 = vecs[n].up;
        ld1 = vecs[n].ld;   d1 = vecs[n].d[2:0];
      end
      e.idx = n; e.dut = vecs[n].dut; e.q = vecs[n].q;
      e.tc = vecs[n].tc; e.wrap = vecs[n].wrap;
      sb.push_back(e);
      @(posedge clk);
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("jk_never_both", jk_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jk_sync_counter.md
# jk_sync_counter

Synchronous modulo-N up/down counter whose state bits are held in JK flip-flop cells. It consumes the q outputs of its own JK bit cells and generates each cell's j/k drive. It is the next stage above the single JK flip-flop in the sequential-logic library. It provides parallel load, count enable, a terminal-count flag and a one-cycle wrap pulse for cascading.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..16.
- MODULUS, 10: count modulus; legal range 2..2**WIDTH; the count runs 0..MODULUS-1.

- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load request.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  current count.
- q_b  output  WIDTH  bitwise complement of q, taken from the cells' q_b outputs.
- tc  output  1  terminal count; combinational.
- wrap  output  1  registered one-cycle pulse after a wrap-around.

## Operation
- Each bit i lives in one jk_cell.
- Next value n is computed by the control logic. The cell drive is j[i] = n[i] & ~q[i] and k[i] = ~n[i] & q[i].
- When n equals q, every j/k pair is 0, so the cells hold. The j=k=1 condition is never generated.
- Action priority on each clk rising edge:
  1. reset == 0: q ← 0, wrap ← 0.
  2. load == 1: q ← d if d < MODULUS, otherwise q ← MODULUS-1 (saturating). wrap ← 0. en and up are ignored.
  3. en == 1, up == 1: if q == MODULUS-1 then q ← 0 and wrap ← 1; otherwise q ← q+1 and wrap ← 0.
  4. en == 1, up == 0: if q == 0 then q ← MODULUS-1 and wrap ← 1; otherwise q ← q-1 and wrap ← 0.
  5. Otherwise: q holds, wrap ← 0.
- tc = en & ((up & q == MODULUS-1) | (~up & q == 0)). tc is forced to 0 while load is 1 or reset is 0.
- Arithmetic: the comparison and the increment/decrement are done at WIDTH+1 bits, so MODULUS = 2**WIDTH wraps correctly and no overflow escapes into q.
- There is no FSM beyond the count register itself. The count state is q; the only extra register is wrap.
- Reversing direction mid-count takes effect on the next enabled edge with no penalty.

## Timing
- Reset values: q = 0, q_b = all ones, wrap = 0, tc = 0 whenever reset is 0. Once reset releases, tc follows its formula; with en = 1 and up = 0 it is 1 immediately, because q = 0.
- Count, load and reset latency: 1 cycle; q updates on the edge where the request is sampled.
- tc is valid in the same cycle as the en/up/q that produce it, so cascaded stages can use it as their en.
- wrap is high for exactly the one cycle following the wrapping edge. With continuous en at the terminal value, wrap pulses once per MODULUS cycles.
- Reset asserted in the middle of a count, or in the same cycle as load or en, wins: q = 0 on that edge.
- load and en in the same cycle: load wins, no wrap pulse.
- Load of an out-of-range value: one cycle later q = MODULUS-1.

## Structure
- Shared package jk_seq_pkg holds:
  - the jk_action_t enum (HOLD, RESET, SET, TOGGLE), used by jk_cell;
  - the constant function clog2;
  - the default width and modulus constants.
- Sub-module jk_cell: one JK flip-flop bit.
  - Ports: clk, reset (active-low, synchronous), j, k, q, q_b.
  - Behaviour: j=0,k=0 hold; 0,1 clear; 1,0 set; 1,1 toggle.
- jk_sync_counter instantiates WIDTH jk_cells through a generate loop. The next-value, tc and wrap logic sit in the parent.
- Parameter checks: WIDTH and MODULUS ranges are checked at elaboration; an illegal value is a fatal error.

## Test plan
- Reset hold: reset=0 for 3 cycles with en=1, up=1 → q=0, q_b=4'hF, wrap=0, tc=0 throughout.
- Up-count wrap (default parameters): en=1, up=1 for 12 cycles from 0 → q runs 0..9 then 0,1. tc=1 while q=9. wrap=1 only in the cycle where q=0 after the wrap.
- Down-count wrap: load d=2, then en=1, up=0 → q goes 2,1,0,9,8. tc=1 at q=0. wrap pulses once, when q=9.
- Load priority and saturation: load=1 with en=1, d=13 → q=9, wrap=0. load=1 with d=5 → q=5.
- Reset mid-count: at q=7 with en=1, assert reset=0 for one cycle together with load=1 and d=3 → q=0. On the next enabled up edge, q=1.
- Full-range modulus (WIDTH=3, MODULUS=8): count up for 9 cycles from 0 → q goes 0..7, then 0. wrap pulses once. A checker confirms no jk_cell ever sees j=k=1.
